// File: rtl/dso100fb_pixel_mixer.sv
// Pixel output stage: pops framebuffer and 2-bpp overlay FIFOs,
// composites the overlay and registers RGB aligned with VID_DE.
module dso100fb_pixel_mixer #(
    parameter int          OV_WORD_W = 32,
    parameter logic [23:0] BLANK_RGB = 24'h000000
) (
    input  logic                 VIDCLK,
    input  logic                 VID_RST_N,
    input  logic                 VIDEO_FETCH,
    input  logic                 OVERLAY_EN,
    input  logic                 OVERLAY_SYNC,
    input  logic [23:0]          FB_DATA,
    input  logic                 FB_EMPTY,
    output logic                 FB_RD,
    input  logic [OV_WORD_W-1:0] OV_DATA,
    input  logic                 OV_EMPTY,
    output logic                 OV_RD,
    input  logic [23:0]          OVCOLOR1,
    input  logic [23:0]          OVCOLOR2,
    input  logic [23:0]          OVCOLOR3,
    input  logic [23:0]          UNDERFLOW_RGB,
    output logic [23:0]          VID_RGB,
    output logic                 FB_UNDERFLOW,
    output logic                 OV_UNDERFLOW
);

    localparam int NPIX = OV_WORD_W / 2;
    localparam int CW   = $clog2(NPIX);
    localparam int SW   = OV_WORD_W - 2;
    localparam logic [CW-1:0] CLAST = CW'(NPIX - 1);

    logic [23:0]   ovc1_q, ovc1_d, ovc2_q, ovc2_d, ovc3_q, ovc3_d;
    logic [23:0]   unf_q, unf_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          fbu_q, fbu_d, ovu_q, ovu_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sh_q, sh_d;
    logic          en_q, en_d;

    logic          grp0;
    logic [1:0]    code;
    logic [23:0]   base;
    logic [23:0]   mix;

    always_comb begin
        ovc1_d = OVCOLOR1;
        ovc2_d = OVCOLOR2;
        ovc3_d = OVCOLOR3;
        unf_d  = UNDERFLOW_RGB;
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        fbu_d  = fbu_q;
        ovu_d  = ovu_q;
        en_d   = OVERLAY_EN;
        code   = 2'b00;

        grp0  = (cnt_q == '0);
        FB_RD = VID_RST_N & VIDEO_FETCH & ~FB_EMPTY;
        OV_RD = VID_RST_N & OVERLAY_EN & grp0 & ~OV_EMPTY;
        base  = FB_EMPTY ? unf_q : FB_DATA;

        if (OVERLAY_EN) begin
            cnt_d = (cnt_q == CLAST) ? '0 : cnt_q + CW'(1);
            if (grp0) begin
                // An empty FIFO yields a transparent group so alignment holds
                code = OV_EMPTY ? 2'b00 : OV_DATA[1:0];
                sh_d = OV_EMPTY ? '0 : OV_DATA[OV_WORD_W-1:2];
            end else begin
                code = sh_q[1:0];
                sh_d = sh_q >> 2;
            end
        end else if (en_q) begin
            cnt_d = '0;
            sh_d  = '0;
        end

        if (OVERLAY_SYNC) begin
            cnt_d = '0;
            sh_d  = '0;
            fbu_d = 1'b0;
            ovu_d = 1'b0;
        end
        if (VIDEO_FETCH && FB_EMPTY) fbu_d = 1'b1;
        if (OVERLAY_EN && grp0 && OV_EMPTY) ovu_d = 1'b1;

        case (code)
            2'd1:    mix = ovc1_q;
            2'd2:    mix = ovc2_q;
            2'd3:    mix = ovc3_q;
            default: mix = base;
        endcase

        rgb_d = VIDEO_FETCH ? mix : BLANK_RGB;
    end

    always_ff @(posedge VIDCLK or negedge VID_RST_N) begin
        if (!VID_RST_N) begin
            ovc1_q <= '0;
            ovc2_q <= '0;
            ovc3_q <= '0;
            unf_q  <= '0;
            rgb_q  <= '0;
            fbu_q  <= 1'b0;
            ovu_q  <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
            en_q   <= 1'b0;
        end else begin
            ovc1_q <= ovc1_d;
            ovc2_q <= ovc2_d;
            ovc3_q <= ovc3_d;
            unf_q  <= unf_d;
            rgb_q  <= rgb_d;
            fbu_q  <= fbu_d;
            ovu_q  <= ovu_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            en_q   <= en_d;
        end
    end

    assign VID_RGB      = rgb_q;
    assign FB_UNDERFLOW = fbu_q;
    assign OV_UNDERFLOW = ovu_q;

endmodule

// File: doc/dso100fb_pixel_mixer.md
Name: dso100fb_pixel_mixer

Overview:
- Pixel output stage directly downstream of the display timing generator, in the VIDCLK domain.
- Pops framebuffer pixels and packed 2-bpp overlay words from two first-word-fall-through (FWFT) FIFOs, driven by the generator's VIDEO_FETCH / OVERLAY_EN / OVERLAY_SYNC.
- Composites overlay over framebuffer and drives registered RGB aligned with the generator's registered VID_DE (one-cycle latency).
- Detects and flags FIFO underflow per frame.

Parameters:
- OV_WORD_W, 32, overlay FIFO word width; even, >=4; holds OV_WORD_W/2 pixels.
- BLANK_RGB, 24'h000000, RGB driven outside active video.

Ports:
- VIDCLK  in  1  pixel clock
- VID_RST_N  in  1  reset; asynchronous, active-low (clock VIDCLK)
- VIDEO_FETCH  in  1  active-area pixel strobe from timing generator (unregistered DE)
- OVERLAY_EN  in  1  overlay-window pixel strobe; only high when VIDEO_FETCH high
- OVERLAY_SYNC  in  1  one-cycle frame-start pulse
- FB_DATA  in  24  framebuffer FIFO head {R,G,B}
- FB_EMPTY  in  1  framebuffer FIFO empty
- FB_RD  out  1  framebuffer FIFO pop (combinational)
- OV_DATA  in  OV_WORD_W  overlay FIFO head
- OV_EMPTY  in  1  overlay FIFO empty
- OV_RD  out  1  overlay FIFO pop (combinational)
- OVCOLOR1/2/3  in  24 each  colours for overlay codes 1..3; quasi-static, any clock domain
- UNDERFLOW_RGB  in  24  substitute colour on framebuffer underflow; quasi-static
- VID_RGB  out  24  output pixel {R[23:16],G[15:8],B[7:0]}
- FB_UNDERFLOW  out  1  sticky: framebuffer underflow this frame
- OV_UNDERFLOW  out  1  sticky: overlay underflow this frame

Behaviour:
- Reset values:
  - VID_RGB=0; FB_UNDERFLOW=0; OV_UNDERFLOW=0.
  - Unpacker count=0; shift register=0; prev OVERLAY_EN=0.
  - All config registers=0.
- Config capture: OVCOLOR1..3 and UNDERFLOW_RGB are registered into VIDCLK every cycle (one stage); the registered copies are used throughout.
- Framebuffer path, evaluated in cycle t:
  - FB_RD = VIDEO_FETCH && !FB_EMPTY.
  - Base pixel = FB_DATA when popped; UNDERFLOW_RGB when VIDEO_FETCH && FB_EMPTY.
  - Underflow case: no pop, and FB_UNDERFLOW set.
- Overlay unpacker state: count c (0..OV_WORD_W/2-1) and shift register S (OV_WORD_W-2 bits).
- Overlay unpacker, when OVERLAY_EN in cycle t:
  - c==0, !OV_EMPTY: OV_RD=1; code = OV_DATA[1:0]; S <= OV_DATA>>2.
  - c==0, OV_EMPTY: OV_RD=0; code=0; S <= 0 (whole group transparent, keeps alignment); OV_UNDERFLOW set.
  - c!=0: code = S[1:0]; S <= S>>2.
  - c <= c+1, wrapping to 0 after OV_WORD_W/2-1.
  - Pixel 0 of a word is the LSBs.
- Overlay line end: on the OVERLAY_EN falling edge (prev=1, now=0), c <= 0 and the residual S is discarded. Every overlay line starts on a word boundary.
- Compositing:
  - code 0 = transparent, so base pixel passes through.
  - codes 1/2/3 = OVCOLOR1/2/3.
  - Outside OVERLAY_EN, base pixel passes through.
- Output register: VID_RGB at t+1 = composite if VIDEO_FETCH at t, else BLANK_RGB. Latency is exactly 1 cycle, matching the generator's VID_DE register.
- OVERLAY_SYNC:
  - Forces c <= 0 and S <= 0.
  - Clears FB_UNDERFLOW and OV_UNDERFLOW.
  - If a set event occurs in the same cycle, set wins.
- OV_RD is never asserted without OVERLAY_EN. FB_RD is never asserted without VIDEO_FETCH. Neither pop is ever asserted while the matching EMPTY is high.
- Reset mid-line: outputs return to reset values immediately (asynchronous). The FIFOs are not popped while VID_RST_N is low.

Test Plan:
- Reset, then one 4-pixel active line, FB_DATA=24'h112233 constant, OVERLAY_EN low -> FB_RD high for 4 cycles; VID_RGB=112233 on the 4 cycles following, BLANK_RGB otherwise; OV_RD never high.
- OV_WORD_W=32, OVCOLOR1=FF0000, OV_DATA=32'h0000_0001, 16-pixel overlay window -> OV_RD exactly once, in the window's first cycle; first output pixel FF0000, remaining 15 pass FB_DATA.
- 20-pixel overlay window, two words A,B -> OV_RD at pixels 0 and 16; pixels 20..31 of B discarded; next line's first pixel comes from a fresh word (c reset on OVERLAY_EN fall).
- FB_EMPTY high during 3 mid-line active cycles, UNDERFLOW_RGB=00FF00 -> FB_RD low for those cycles; VID_RGB=00FF00 for 3 cycles; FB_UNDERFLOW=1 until next OVERLAY_SYNC, then 0.
- OV_EMPTY at group start -> 16 transparent pixels, OV_UNDERFLOW=1, c continues; next group pops normally.
- Assert VID_RST_N low mid-line -> VID_RGB=0 and flags=0 immediately; FB_RD/OV_RD low; after release the next OVERLAY_SYNC starts clean.
